// File: rtl/mgt_01_fp_cmp_pipe_pkg.sv
// Shared types and helpers for the pipelined floating-point compare unit.
package mgt_01_fp_cmp_pipe_pkg;

  typedef enum logic [2:0] {
    FMIN_ = 3'd0,
    FMAX_ = 3'd1,
    FEQ_  = 3'd2,
    FLT_  = 3'd3,
    FLE_  = 3'd4
  } fcmp_ops;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
    logic is_inf;
  } fp_class_t;

  localparam int unsigned NAN_MAX_W = 128;

  // Canonical quiet NaN for a given format, right-aligned; callers truncate to their width.
  function automatic logic [NAN_MAX_W-1:0] canon_nan(input int unsigned exp_w,
                                                     input int unsigned mant_w);
    logic [NAN_MAX_W-1:0] one;
    one = NAN_MAX_W'(1);
    return (((one << exp_w) - one) << mant_w) | (one << (mant_w - 1));
  endfunction

endpackage

// File: rtl/mgt_01_fp_classify.sv
// Combinational IEEE-754 operand classifier (sign-independent classes only).
module mgt_01_fp_classify
  import mgt_01_fp_cmp_pipe_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic [EXP_W+MANT_W-1:0] operand,
  output fp_class_t               cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;
  logic              exp_ones;
  logic              exp_zero;
  logic              mant_zero;

  assign exp_f     = operand[EXP_W+MANT_W-1:MANT_W];
  assign mant_f    = operand[MANT_W-1:0];
  assign exp_ones  = &exp_f;
  assign exp_zero  = ~|exp_f;
  assign mant_zero = ~|mant_f;

  assign cls.is_nan  = exp_ones & ~mant_zero;
  assign cls.is_snan = exp_ones & ~mant_zero & ~mant_f[MANT_W-1];
  assign cls.is_zero = exp_zero & mant_zero;
  assign cls.is_inf  = exp_ones & mant_zero;

endmodule

// File: rtl/mgt_01_fp_cmp_pipe.sv
// Two-stage FMIN/FMAX/FEQ/FLT/FLE unit with valid/ready handshake and backpressure.
module mgt_01_fp_cmp_pipe
  import mgt_01_fp_cmp_pipe_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [EXP_W+MANT_W:0]       operand_a_i,
  input  logic [EXP_W+MANT_W:0]       operand_b_i,
  input  logic [2:0]                  op_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [EXP_W+MANT_W:0]       result_o,
  output logic                        invalid_o,
  output logic [TAG_W-1:0]            tag_o
);

  localparam int unsigned W = 1 + EXP_W + MANT_W;
  localparam logic [W-1:0] CANON_NAN = W'(canon_nan(EXP_W, MANT_W));

  fp_class_t cls_a, cls_b;
  logic      a_lt_b_c, a_eq_b_c;
  logic      accept, s1_advance, s2_advance;

  logic             s1_valid;
  logic [W-1:0]     s1_a, s1_b;
  fcmp_ops          s1_op;
  logic [TAG_W-1:0] s1_tag;
  fp_class_t        s1_cls_a, s1_cls_b;
  logic             s1_lt, s1_eq;

  logic [W-1:0] res_c;
  logic         inv_c;
  logic         unused_inf_c;

  mgt_01_fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
    .operand (operand_a_i[W-2:0]),
    .cls     (cls_a)
  );

  mgt_01_fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
    .operand (operand_b_i[W-2:0]),
    .cls     (cls_b)
  );

  assign s2_advance = ~valid_o | ready_i;
  assign s1_advance = ~s1_valid | s2_advance;
  assign ready_o    = s1_advance;
  assign accept     = valid_i & ready_o;

  // Total order on non-NaN values with -0 below +0; FEQ/FLT/FLE fold zeros later.
  always_comb begin
    a_lt_b_c = 1'b0;
    a_eq_b_c = (operand_a_i == operand_b_i);
    if (operand_a_i[W-1] != operand_b_i[W-1]) begin
      a_lt_b_c = operand_a_i[W-1];
    end else if (operand_a_i[W-1]) begin
      a_lt_b_c = (operand_a_i[W-2:0] > operand_b_i[W-2:0]);
    end else begin
      a_lt_b_c = (operand_a_i[W-2:0] < operand_b_i[W-2:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_a     <= operand_a_i;
      s1_b     <= operand_b_i;
      s1_op    <= fcmp_ops'(op_i);
      s1_tag   <= tag_i;
      s1_cls_a <= cls_a;
      s1_cls_b <= cls_b;
      s1_lt    <= a_lt_b_c;
      s1_eq    <= a_eq_b_c;
    end
  end

  // Infinities need no special handling: the bit-pattern ordering already places them.
  assign unused_inf_c = s1_cls_a.is_inf ^ s1_cls_b.is_inf;

  always_comb begin
    logic any_nan, any_snan, both_zero, pick_a;
    res_c     = '0;
    inv_c     = 1'b0;
    any_nan   = s1_cls_a.is_nan | s1_cls_b.is_nan;
    any_snan  = s1_cls_a.is_snan | s1_cls_b.is_snan;
    both_zero = s1_cls_a.is_zero & s1_cls_b.is_zero;
    pick_a    = (s1_op == FMIN_) ? s1_lt : ~s1_lt;
    case (s1_op)
      FEQ_: begin
        res_c = W'(~any_nan & (s1_eq | both_zero));
        inv_c = any_snan;
      end
      FLT_: begin
        res_c = W'(~any_nan & s1_lt & ~both_zero);
        inv_c = any_nan;
      end
      FLE_: begin
        res_c = W'(~any_nan & (s1_lt | s1_eq | both_zero));
        inv_c = any_nan;
      end
      default: begin
        if (s1_cls_a.is_nan & s1_cls_b.is_nan) begin
          res_c = CANON_NAN;
        end else if (s1_cls_a.is_nan) begin
          res_c = s1_b;
        end else if (s1_cls_b.is_nan) begin
          res_c = s1_a;
        end else begin
          res_c = pick_a ? s1_a : s1_b;
        end
        inv_c = ((s1_op == FMIN_) | (s1_op == FMAX_)) & any_snan;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      invalid_o <= 1'b0;
      tag_o     <= '0;
    end else if (s2_advance) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        result_o  <= res_c;
        invalid_o <= inv_c;
        tag_o     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_mgt_01_fp_cmp_pipe.sv
// Self-checking bench: directed vectors, backpressure, reset and randomized traffic vs a value model.
module tb_mgt_01_fp_cmp_pipe;
  import mgt_01_fp_cmp_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        valid_i, ready_o, valid_o, ready_i, invalid_o;
  logic [31:0] operand_a_i, operand_b_i, result_o;
  logic [2:0]  op_i;
  logic [4:0]  tag_i, tag_o;

  logic        v_dp, rdy_o_dp, vo_dp, rdy_i_dp, inv_dp;
  logic [63:0] a_dp, b_dp, res_dp;
  logic [2:0]  op_dp;
  logic [4:0]  tag_dp, tago_dp;

  mgt_01_fp_cmp_pipe dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .op_i(op_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .invalid_o(invalid_o),
    .tag_o(tag_o)
  );

  mgt_01_fp_cmp_pipe #(.EXP_W(11), .MANT_W(52), .TAG_W(5)) dut_dp (
    .clk_i(clk), .rst_i(rst_i), .valid_i(v_dp), .ready_o(rdy_o_dp),
    .operand_a_i(a_dp), .operand_b_i(b_dp), .op_i(op_dp), .tag_i(tag_dp),
    .valid_o(vo_dp), .ready_i(rdy_i_dp), .result_o(res_dp), .invalid_o(inv_dp),
    .tag_o(tago_dp)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] bp_a [4] = '{32'h3F800000, 32'h7F800001, 32'hC0000000, 32'h00000000};
  logic [31:0] bp_b [4] = '{32'h40000000, 32'h3F800000, 32'hBF800000, 32'h80000000};
  logic [2:0]  bp_o [4] = '{3'd0, 3'd1, 3'd3, 3'd2};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Value-level model: orders non-NaN operands by their signed real-number rank.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] t);
    exp_t   e;
    logic   nx, ny, sx, sy;
    longint kx, ky;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    sx = nx && !x[22];
    sy = ny && !y[22];
    kx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    ky = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
    e.tag = t;
    e.inv = 1'b0;
    e.res = 32'd0;
    case (o)
      3'd2: begin e.res = {31'd0, !nx && !ny && kx == ky}; e.inv = sx || sy; end
      3'd3: begin e.res = {31'd0, !nx && !ny && kx <  ky}; e.inv = nx || ny; end
      3'd4: begin e.res = {31'd0, !nx && !ny && kx <= ky}; e.inv = nx || ny; end
      default: begin
        if (nx && ny)      e.res = 32'h7FC00000;
        else if (nx)       e.res = y;
        else if (ny)       e.res = x;
        else if (kx == ky) e.res = ((o == 3'd0) == x[31]) ? x : y;
        else if (o == 3'd0) e.res = (kx < ky) ? x : y;
        else               e.res = (kx > ky) ? x : y;
        e.inv = (o <= 3'd1) && (sx || sy);
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return {r[31], 31'h7F800000};
      3: return {r[31], 8'hFF, 1'b1, r[21:0]};
      4: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      5: return {r[31], 6'b011111, r[1:0], r[22:0]};
      default: return r;
    endcase
  endfunction

  // One handshake cycle: score outputs, record accepted input, advance past the edge.
  task automatic cycle(output bit acc);
    #1;
    acc = valid_i && ready_o;
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        chk("res", 64'(result_o), 64'(exp_q[0].res));
        chk("inv", 64'(invalid_o), 64'(exp_q[0].inv));
        chk("tag", 64'(tag_o), 64'(exp_q[0].tag));
        if (ready_i) void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(model(op_i, operand_a_i, operand_b_i, tag_i));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] er, input logic ei);
    int         lat;
    logic [4:0] t;
    t = tag_i + 5'd1;
    op_i = o; operand_a_i = ia; operand_b_i = ib; tag_i = t; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    chk({name, "_ready"}, 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 8) begin @(posedge clk); #1; lat++; end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_res"}, 64'(result_o), 64'(er));
    chk({name, "_inv"}, 64'(invalid_o), 64'(ei));
    chk({name, "_tag"}, 64'(tag_o), 64'(t));
    @(posedge clk); #1;
  endtask

  task automatic directed_dp(input string name, input logic [2:0] o, input logic [63:0] ia,
                             input logic [63:0] ib, input logic [63:0] er, input logic ei);
    int lat;
    op_dp = o; a_dp = ia; b_dp = ib; tag_dp = tag_dp + 5'd1; v_dp = 1'b1;
    #1;
    chk({name, "_ready"}, 64'(rdy_o_dp), 64'd1);
    @(posedge clk); #1;
    v_dp = 1'b0;
    lat = 1;
    while (!vo_dp && lat < 8) begin @(posedge clk); #1; lat++; end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_res"}, res_dp, er);
    chk({name, "_inv"}, 64'(inv_dp), 64'(ei));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] x;
    int          r;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = 3'd0; tag_i = 5'd0;
    operand_a_i = 32'd0; operand_b_i = 32'd0;
    v_dp = 1'b0; rdy_i_dp = 1'b1; op_dp = 3'd0; tag_dp = 5'd0; a_dp = 64'd0; b_dp = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_result_o", 64'(result_o), 64'd0);
    chk("rst_invalid_o", 64'(invalid_o), 64'd0);
    chk("rst_tag_o", 64'(tag_o), 64'd0);
    chk("rst_dp_valid_o", 64'(vo_dp), 64'd0);
    @(posedge clk); #1;

    directed("fmin_zeros",   3'(FMIN_), 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
    directed("fmin_zeros_r", 3'(FMIN_), 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    directed("fmax_zeros",   3'(FMAX_), 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    directed("fmin_neg",     3'(FMIN_), 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0);
    directed("fmax_neg",     3'(FMAX_), 32'hC0000000, 32'hBF800000, 32'hBF800000, 1'b0);
    directed("fmax_qnan",    3'(FMAX_), 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0);
    directed("fmax_snan",    3'(FMAX_), 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
    directed("fmax_2snan",   3'(FMAX_), 32'h7F800001, 32'h7F800001, 32'h7FC00000, 1'b1);
    directed("feq_qnan",     3'(FEQ_),  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0);
    directed("flt_qnan",     3'(FLT_),  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1);
    directed("fle_ninf",     3'(FLE_),  32'hFF800000, 32'hBF800000, 32'h00000001, 1'b0);
    directed("feq_zeros",    3'(FEQ_),  32'h80000000, 32'h00000000, 32'h00000001, 1'b0);
    directed("flt_zeros",    3'(FLT_),  32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    directed("undef_op",     3'd7,      32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b0);

    directed_dp("dp_fmin", 3'(FMIN_), 64'hBFF0000000000000, 64'h4000000000000000,
                64'hBFF0000000000000, 1'b0);
    directed_dp("dp_fmax_2snan", 3'(FMAX_), 64'h7FF0000000000001, 64'h7FF0000000000001,
                64'h7FF8000000000000, 1'b1);

    // Four back-to-back ops with a three-cycle downstream stall in the middle.
    exp_q.delete();
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
      ready_i = !(c >= 1 && c <= 3);
      valid_i = (idx < 4);
      op_i = bp_o[idx % 4]; operand_a_i = bp_a[idx % 4]; operand_b_i = bp_b[idx % 4];
      tag_i = 5'(10 + idx);
      if (c == 2 || c == 3) begin
        #1;
        chk("bp_ready_low", 64'(ready_o), 64'd0);
      end
      cycle(acc);
      if (acc) idx++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("bp_issued", 64'(idx), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 9) < 7);
      op_i = 3'($urandom_range(0, 7));
      x = rnd_fp();
      operand_a_i = x;
      r = $urandom_range(0, 9);
      if (r < 2)      operand_b_i = x;
      else if (r < 4) operand_b_i = {~x[31], x[30:0]};
      else            operand_b_i = rnd_fp();
      tag_i = 5'($urandom);
      cycle(acc);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(acc);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Fill both stages under stall, then reset.
    ready_i = 1'b0; valid_i = 1'b1; op_i = 3'(FMAX_);
    operand_a_i = 32'h7F800001; operand_b_i = 32'h3F800000; tag_i = 5'h1F;
    cycle(acc);
    tag_i = 5'h1E;
    cycle(acc);
    valid_i = 1'b0;
    #1;
    chk("full_valid_o", 64'(valid_o), 64'd1);
    chk("full_ready_o", 64'(ready_o), 64'd0);
    chk("full_result_o", 64'(result_o), 64'h3F800000);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_valid_o", 64'(valid_o), 64'd0);
    chk("mid_rst_ready_o", 64'(ready_o), 64'd1);
    chk("mid_rst_result_o", 64'(result_o), 64'd0);
    chk("mid_rst_invalid_o", 64'(invalid_o), 64'd0);
    chk("mid_rst_tag_o", 64'(tag_o), 64'd0);
    exp_q.delete();
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_flushed", 64'(valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
